oam_dma: RTL and testbench

- Sprite DMA controller on the CPU bus. A host write of page P to P_trigger_addr starts a 256-byte copy from CPU address {P,8'h00}..{P,8'hFF} to the PPU OAM data port P_dest_addr.
- The block halts the core, owns the CPU address/data bus for the copy, then returns the bus to the core.
- It sits between core and bus decoder: a top-level mux selects O_dma_* over core bus signals while O_bus_own=1.

---
 rtl/oam_dma.sv | 132 +++++++++++++
 tb/tb_oam_dma.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: halts the core and copies one 256-byte page to the OAM data port.
// All state and outputs advance only on I_tick; outputs are registered from the next state.
module oam_dma #(
  parameter logic [15:0] P_trigger_addr = 16'h4014,
  parameter logic [15:0] P_dest_addr    = 16'h2004,
  parameter int          P_count_bits   = 8
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic [15:0] I_cpu_addr,
  input  logic        I_cpu_wren,
  input  logic [7:0]  I_cpu_data,
  output logic        O_halt_req,
  input  logic        I_halt_ack,
  output logic        O_bus_own,
  output logic [15:0] O_dma_addr,
  output logic        O_dma_rdwr,
  output logic        O_dma_wren,
  output logic [7:0]  O_dma_data,
  input  logic [7:0]  I_dma_rd_data,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_DUMMY = 3'd2,
    S_ALIGN = 3'd3,
    S_READ  = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    parity_q, parity_d;
  logic [7:0]              page_q, page_d;
  logic [P_count_bits-1:0] idx_q, idx_d;
  logic                    halt_req_q, halt_req_d;
  logic                    bus_own_q, bus_own_d;
  logic [15:0]             addr_q, addr_d;
  logic                    rdwr_q, rdwr_d;
  logic                    wren_q, wren_d;
  logic [7:0]              data_q, data_d;
  logic                    busy_q, busy_d;
  logic [15:0]             rd_addr;

  always_comb begin
    state_d    = state_q;
    parity_d   = parity_q;
    page_d     = page_q;
    idx_d      = idx_q;
    halt_req_d = halt_req_q;
    bus_own_d  = bus_own_q;
    addr_d     = addr_q;
    rdwr_d     = rdwr_q;
    wren_d     = wren_q;
    data_d     = data_q;
    busy_d     = busy_q;
    rd_addr    = 16'h0000;
    if (I_tick) begin
      parity_d = ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (I_cpu_wren && (I_cpu_addr == P_trigger_addr)) begin
            page_d  = I_cpu_data;
            idx_d   = '0;
            state_d = S_HALT;
          end
        end
        S_HALT:  if (I_halt_ack) state_d = S_DUMMY;
        // parity_q is the current cycle; a GET dummy means the next cycle is PUT, so burn one
        S_DUMMY: state_d = parity_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = I_dma_rd_data;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          idx_d   = idx_q + P_count_bits'(1);
          state_d = (&idx_q) ? S_IDLE : S_READ;
        end
        default: state_d = S_IDLE;
      endcase
      rd_addr                   = {page_d, 8'h00};
      rd_addr[P_count_bits-1:0] = idx_d;
      halt_req_d = (state_d != S_IDLE);
      busy_d     = (state_d != S_IDLE);
      bus_own_d  = (state_d == S_READ) || (state_d == S_WRITE);
      wren_d     = (state_d == S_WRITE);
      rdwr_d     = (state_d != S_WRITE);
      if (state_d == S_READ)  addr_d = rd_addr;
      if (state_d == S_WRITE) addr_d = P_dest_addr;
    end
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      page_q     <= 8'h00;
      idx_q      <= '0;
      halt_req_q <= 1'b0;
      bus_own_q  <= 1'b0;
      addr_q     <= 16'h0000;
      rdwr_q     <= 1'b0;
      wren_q     <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      halt_req_q <= halt_req_d;
      bus_own_q  <= bus_own_d;
      addr_q     <= addr_d;
      rdwr_q     <= rdwr_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign O_halt_req = halt_req_q;
  assign O_bus_own  = bus_own_q;
  assign O_dma_addr = addr_q;
  assign O_dma_rdwr = rdwr_q;
  assign O_dma_wren = wren_q;
  assign O_dma_data = data_q;
  assign O_busy     = busy_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed bench for oam_dma against a bench-owned page memory.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_data = 8'h00;
  logic        halt_req;
  logic        halt_ack = 1'b0;
  logic        bus_own;
  logic [15:0] dma_addr;
  logic        dma_rdwr;
  logic        dma_wren;
  logic [7:0]  dma_data;
  logic [7:0]  dma_rd_data;
  logic        busy;

  logic [7:0] mem [0:65535];
  int vec = 0;
  int miss = 0;
  int tick_cnt = 0;

  assign dma_rd_data = mem[dma_addr];

  always #5 clk = ~clk;

  oam_dma dut (
    .I_clock(clk), .I_reset(rst_n), .I_tick(tick),
    .I_cpu_addr(cpu_addr), .I_cpu_wren(cpu_wren), .I_cpu_data(cpu_data),
    .O_halt_req(halt_req), .I_halt_ack(halt_ack), .O_bus_own(bus_own),
    .O_dma_addr(dma_addr), .O_dma_rdwr(dma_rdwr), .O_dma_wren(dma_wren),
    .O_dma_data(dma_data), .I_dma_rd_data(dma_rd_data), .O_busy(busy)
  );

  function automatic logic [7:0] exp_byte(input logic [7:0] page, input int idx);
    logic [7:0] i8;
    i8 = idx[7:0];
    return (page == 8'h02) ? (i8 ^ 8'hA5) : (i8 + 8'h30);
  endfunction

  task automatic tick_once();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    tick_cnt++;
  endtask

  task automatic apply_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vec++;
    if ({halt_req, bus_own, dma_rdwr, dma_wren, busy} !== 5'b0 || dma_addr !== 16'h0 || dma_data !== 8'h0) begin
      miss++;
      $display("FAIL reset_state: got halt=%b own=%b rdwr=%b wren=%b busy=%b addr=%h data=%h, want all 0",
               halt_req, bus_own, dma_rdwr, dma_wren, busy, dma_addr, dma_data);
    end
  endtask

  task automatic test_idle_traffic();
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) begin
        cpu_addr = 16'h4014; cpu_wren = 1'b0; cpu_data = 8'h02;
      end else begin
        cpu_addr = 16'($urandom_range(0, 16'h4013)); cpu_wren = 1'($urandom_range(0, 1));
        cpu_data = 8'($urandom_range(0, 255));
      end
      tick_once();
      vec++;
      if ({busy, halt_req, bus_own} !== 3'b000) begin
        miss++;
        $display("FAIL idle_traffic[%0d]: busy/halt/own=%b want 000 addr=%h wren=%b", i, {busy, halt_req, bus_own}, cpu_addr, cpu_wren);
      end
    end
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
  endtask

  // Trigger, ack two ticks later, then follow every CPU cycle to completion.
  task automatic xfer(input logic [7:0] page, input bit want_align, input int abort_after,
                      input int freeze_at, input bit inject);
    int n, reads, writes, exp_idx;
    bit arm;
    logic [15:0] exp_addr, f_addr;
    logic [7:0]  f_data;
    while ((tick_cnt % 2) != (want_align ? 1 : 0)) tick_once();
    cpu_addr = 16'h4014; cpu_wren = 1'b1; cpu_data = page;
    tick_once();
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
    vec++;
    if ({halt_req, busy, bus_own} !== 3'b110) begin
      miss++; $display("FAIL trigger_halt: halt/busy/own=%b want 110", {halt_req, busy, bus_own});
    end
    tick_once();
    halt_ack = 1'b1;
    tick_once();
    vec++;
    if ({halt_req, bus_own} !== 2'b10) begin
      miss++; $display("FAIL dummy_state: halt/own=%b want 10", {halt_req, bus_own});
    end
    reads = 0; writes = 0; exp_idx = 0; arm = 1'b0;
    for (n = 1; n <= 600; n++) begin
      if (arm) begin cpu_addr = 16'h4014; cpu_wren = 1'b1; cpu_data = 8'h05; end
      tick_once();
      cpu_wren = 1'b0; cpu_addr = 16'h0000; arm = 1'b0;
      if (n == 1) begin
        halt_ack = 1'b0;
        vec++;
        if (bus_own !== !want_align) begin
          miss++; $display("FAIL align_slot: bus_own=%b want %b", bus_own, !want_align);
        end
      end
      if (!busy) break;
      if (bus_own && dma_rdwr && !dma_wren) begin
        exp_addr = {page, 8'h00} | 16'(exp_idx);
        vec++;
        if (dma_addr !== exp_addr || tick_cnt[0] !== 1'b0) begin
          miss++; $display("FAIL read_addr[%0d]: addr=%h parity=%0d want %h parity 0", exp_idx, dma_addr, tick_cnt % 2, exp_addr);
        end
        reads++;
        if (freeze_at != 0 && reads == freeze_at) begin
          f_addr = dma_addr; f_data = dma_data;
          repeat (10) @(negedge clk);
          vec++;
          if (dma_addr !== f_addr || dma_data !== f_data || bus_own !== 1'b1 || dma_rdwr !== 1'b1) begin
            miss++; $display("FAIL freeze: addr=%h data=%h own=%b rdwr=%b want %h %h 1 1", dma_addr, dma_data, bus_own, dma_rdwr, f_addr, f_data);
          end
        end
      end else if (dma_wren) begin
        vec++;
        if (dma_addr !== 16'h2004 || dma_data !== exp_byte(page, exp_idx) || dma_rdwr !== 1'b0) begin
          miss++; $display("FAIL write[%0d]: addr=%h data=%h rdwr=%b want 2004 %h 0", exp_idx, dma_addr, dma_data, dma_rdwr, exp_byte(page, exp_idx));
        end
        if (inject && (exp_idx == 50 || exp_idx == 255)) arm = 1'b1;
        exp_idx++; writes++;
        if (abort_after != 0 && writes == abort_after) begin
          #3 rst_n = 1'b0;
          #1 vec++;
          if ({halt_req, bus_own, dma_rdwr, dma_wren, busy} !== 5'b0 || dma_addr !== 16'h0 || dma_data !== 8'h0) begin
            miss++; $display("FAIL async_abort: halt=%b own=%b rdwr=%b wren=%b busy=%b addr=%h data=%h want all 0",
                             halt_req, bus_own, dma_rdwr, dma_wren, busy, dma_addr, dma_data);
          end
          repeat (2) @(negedge clk);
          rst_n = 1'b1; tick_cnt = 0;
          return;
        end
      end
    end
    vec++;
    if (n !== (want_align ? 514 : 513) || reads !== 256 || writes !== 256) begin
      miss++; $display("FAIL xfer_len: ticks=%0d reads=%0d writes=%0d want %0d 256 256", n, reads, writes, want_align ? 514 : 513);
    end
    vec++;
    if ({halt_req, bus_own, dma_wren, dma_rdwr} !== 4'b0001) begin
      miss++; $display("FAIL done_outputs: halt/own/wren/rdwr=%b want 0001", {halt_req, bus_own, dma_wren, dma_rdwr});
    end
    repeat (4) tick_once();
    vec++;
    if (busy !== 1'b0 || halt_req !== 1'b0) begin
      miss++; $display("FAIL no_restart: busy=%b halt=%b want 0 0", busy, halt_req);
    end
  endtask

  task automatic test_xfer_aligned();   xfer(8'h02, 1'b0, 0, 0, 1'b0);  endtask
  task automatic test_xfer_align();     xfer(8'h02, 1'b1, 0, 0, 1'b0);  endtask
  task automatic test_reset_abort();    xfer(8'h02, 1'b0, 100, 0, 1'b0); xfer(8'h07, 1'b0, 0, 0, 1'b0); endtask
  task automatic test_retrigger();      xfer(8'h02, 1'b1, 0, 0, 1'b1);  endtask
  task automatic test_freeze();         xfer(8'h02, 1'b0, 0, 30, 1'b0); endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0700 + i] = 8'(i) + 8'h30;
    end
    test_reset();
    test_idle_traffic();
    test_xfer_aligned();
    test_xfer_align();
    test_reset_abort();
    test_retrigger();
    test_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
